spw_link_start_seq: RTL

//  Link start sequencer between the auto_start PIO and the SpaceWire link core.

---
 rtl/spw_link_start_pkg.sv | 27 ++
 rtl/spw_seq_timer.sv | 33 +++
 rtl/spw_link_start_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spw_link_start_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spw_link_start_pkg
// Brief    : State encoding, register map and helpers for the link sequencer.
// Revision : 1.0
// ============================================================================
package spw_link_start_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_WAIT_RUN = 3'd2,
      ST_RUNNING  = 3'd3,
      ST_BACKOFF  = 3'd4
   } seq_state_t;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_RETRY  = 2'd1;
   localparam logic [1:0] ADDR_ERR    = 2'd2;

   // States in which the core is asked to start (and not held disabled)
   function automatic logic drives_link(input seq_state_t s);
      return (s == ST_START) || (s == ST_WAIT_RUN) || (s == ST_RUNNING);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spw_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : spw_seq_timer
// Brief    : Loadable down-counter with enable and zero flag; holds at zero.
// Revision : 1.0
// ============================================================================
module spw_seq_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             enable,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/spw_link_start_seq.sv
`default_nettype none
// ============================================================================
// Module   : spw_link_start_seq
// Brief    : SpaceWire link start sequencer with connect timeout, retry
//            backoff, saturating retry/error counters and Avalon-MM status.
// Revision : 1.0
// ============================================================================
module spw_link_start_seq
   import spw_link_start_pkg::*;
#(
   parameter int CONNECT_TIMEOUT = 12800,
   parameter int RETRY_WAIT      = 6400,
   parameter int CNT_W           = 16,
   parameter int STAT_W          = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        auto_start_in,
   input  logic        link_running_in,
   input  logic        link_error_in,
   output logic        link_start_out,
   output logic        link_disable_out,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
);

   localparam logic [CNT_W-1:0] CONNECT_LOAD = CNT_W'(CONNECT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RETRY_LOAD   = CNT_W'(RETRY_WAIT - 1);

   seq_state_t        state;
   seq_state_t        state_nx;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_en;
   logic              tmr_zero;
   logic              retry_inc;
   logic              err_inc;
   logic              cnt_clr;
   logic [STAT_W-1:0] retry_cnt;
   logic [STAT_W-1:0] err_cnt;
   logic              unused_wdata;

   assign unused_wdata = ^writedata;

   spw_seq_timer #(
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .enable   (tmr_en),
      .zero     (tmr_zero)
   );

   assign tmr_en  = (state == ST_WAIT_RUN) || (state == ST_BACKOFF);
   assign cnt_clr = chipselect && !write_n && (address == ADDR_RETRY);

   always_comb begin
      state_nx  = state;
      tmr_load  = 1'b0;
      tmr_val   = CONNECT_LOAD;
      retry_inc = 1'b0;
      err_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (auto_start_in) state_nx = ST_START;
         end
         ST_START: begin
            state_nx = ST_WAIT_RUN;
            tmr_load = 1'b1;
            tmr_val  = CONNECT_LOAD;
         end
         ST_WAIT_RUN: begin
            if (link_running_in) begin
               state_nx = ST_RUNNING;
            end else if (link_error_in || tmr_zero) begin
               state_nx  = ST_BACKOFF;
               tmr_load  = 1'b1;
               tmr_val   = RETRY_LOAD;
               retry_inc = 1'b1;
            end
         end
         ST_RUNNING: begin
            if (link_error_in || !link_running_in) begin
               state_nx = ST_BACKOFF;
               tmr_load = 1'b1;
               tmr_val  = RETRY_LOAD;
               err_inc  = 1'b1;
            end
         end
         ST_BACKOFF: begin
            if (tmr_zero) state_nx = ST_START;
         end
         default: state_nx = ST_IDLE;
      endcase
      // Dropping auto-start aborts everything, including counter updates
      if ((state != ST_IDLE) && !auto_start_in) begin
         state_nx  = ST_IDLE;
         tmr_load  = 1'b0;
         retry_inc = 1'b0;
         err_inc   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_IDLE;
         link_start_out   <= 1'b0;
         link_disable_out <= 1'b1;
      end else begin
         state            <= state_nx;
         link_start_out   <= drives_link(state_nx);
         link_disable_out <= !drives_link(state_nx);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retry_cnt <= '0;
         err_cnt   <= '0;
      end else if (cnt_clr) begin
         retry_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (retry_inc && (retry_cnt != '1)) retry_cnt <= retry_cnt + 1'b1;
         if (err_inc && (err_cnt != '1))     err_cnt   <= err_cnt + 1'b1;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_STATUS: readdata = {28'b0, state, link_running_in};
         ADDR_RETRY:  readdata = 32'(retry_cnt);
         ADDR_ERR:    readdata = 32'(err_cnt);
         default:     readdata = '0;
      endcase
   end

endmodule
`default_nettype wire
